// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// used by both the 8N1 receiver and its matching transmitter.
package uart_pkg;

   // 50 MHz system clock / 115200 baud
   localparam int CLKS_PER_BIT_DEFAULT = 434;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4,
      BREAK   = 3'd5
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit. The reset value is
// parameterised so an idle-high serial line comes out of reset as idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_D,
   output logic o_Q
);

   logic r_Meta;
   logic r_Sync;

   // Shift the asynchronous input through two flops to settle metastability
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Meta <= RST_VAL;
         r_Sync <= RST_VAL;
      end else begin
         r_Meta <= i_D;
         r_Sync <= r_Meta;
      end
   end

   assign o_Q = r_Sync;

endmodule

// File: rtl/rx_serial_8n1.sv
// UART 8N1 receiver: synchronises the raw line, confirms the start bit at its
// midpoint, samples each data bit mid-bit (LSB first), checks the stop bit and
// reports either a one-cycle data-valid pulse or a one-cycle framing error.
// After a framing error the receiver waits for the line to return high so a
// held-low line (break) cannot immediately re-trigger a new frame.
module rx_serial_8n1
   import uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte,
   output logic       o_Rx_Active,
   output logic       o_Rx_Error
);

   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t        r_State;
   rx_state_t        w_Next_State;
   logic [CNT_W-1:0] r_Clock_Count;
   logic [2:0]       r_Bit_Index;
   logic [7:0]       r_Shift;
   logic [7:0]       r_Rx_Byte;
   logic             r_Rx_DV;
   logic             r_Rx_Active;
   logic             r_Rx_Error;
   logic             w_Rx;
   logic             w_Mid_Bit;
   logic             w_Bit_Done;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_D     (i_Rx_Serial),
      .o_Q     (w_Rx)
   );

   assign w_Mid_Bit  = (r_Clock_Count == HALF_BIT);
   assign w_Bit_Done = (r_Clock_Count == LAST_CLK);

   // State register
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_State <= IDLE;
      end else begin
         r_State <= w_Next_State;
      end
   end

   // Next-state decode from the synchronised line and bit-timing strobes
   always_comb begin
      w_Next_State = r_State;
      case (r_State)
         IDLE:    if (!w_Rx) w_Next_State = START;
         START:   if (w_Mid_Bit) w_Next_State = w_Rx ? IDLE : DATA;
         DATA:    if (w_Bit_Done && (r_Bit_Index == 3'd7)) w_Next_State = STOP;
         STOP:    if (w_Bit_Done) w_Next_State = w_Rx ? CLEANUP : BREAK;
         CLEANUP: w_Next_State = IDLE;
         BREAK:   if (w_Rx) w_Next_State = IDLE;
         default: w_Next_State = IDLE;
      endcase
   end

   // Bit timing, shift register and registered outputs; DV/Error default low
   // each cycle so they can only ever be single-cycle pulses
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Clock_Count <= '0;
         r_Bit_Index   <= 3'd0;
         r_Shift       <= 8'h00;
         r_Rx_Byte     <= 8'h00;
         r_Rx_DV       <= 1'b0;
         r_Rx_Active   <= 1'b0;
         r_Rx_Error    <= 1'b0;
      end else begin
         r_Rx_DV    <= 1'b0;
         r_Rx_Error <= 1'b0;
         case (r_State)
            IDLE: begin
               r_Clock_Count <= '0;
               r_Bit_Index   <= 3'd0;
            end
            START: begin
               if (w_Mid_Bit) begin
                  r_Clock_Count <= '0;
                  if (!w_Rx) r_Rx_Active <= 1'b1;
               end else begin
                  r_Clock_Count <= r_Clock_Count + 1'b1;
               end
            end
            DATA: begin
               if (w_Bit_Done) begin
                  r_Clock_Count        <= '0;
                  r_Shift[r_Bit_Index] <= w_Rx;
                  // Wraps 7 -> 0 on the last data bit
                  r_Bit_Index          <= r_Bit_Index + 3'd1;
               end else begin
                  r_Clock_Count <= r_Clock_Count + 1'b1;
               end
            end
            STOP: begin
               if (w_Bit_Done) begin
                  r_Clock_Count <= '0;
                  r_Rx_Active   <= 1'b0;
                  if (w_Rx) begin
                     r_Rx_Byte <= r_Shift;
                     r_Rx_DV   <= 1'b1;
                  end else begin
                     r_Rx_Error <= 1'b1;
                  end
               end else begin
                  r_Clock_Count <= r_Clock_Count + 1'b1;
               end
            end
            default: begin
               r_Clock_Count <= '0;
               r_Bit_Index   <= 3'd0;
            end
         endcase
      end
   end

   assign o_Rx_DV     = r_Rx_DV;
   assign o_Rx_Byte   = r_Rx_Byte;
   assign o_Rx_Active = r_Rx_Active;
   assign o_Rx_Error  = r_Rx_Error;

endmodule
